// File: rtl/avalon_master_bridge.sv
// Avalon-MM master front end: turns row/column pixel read/write requests from the
// cartoonifier core into word-addressed SDRAM transactions and returns completions.
module avalon_master_bridge #(
   parameter int          IMG_WIDTH  = 640,
   parameter int          IMG_HEIGHT = 480,
   parameter logic [31:0] RD_BASE    = 32'h0000_0000,
   parameter logic [31:0] WR_BASE    = 32'h0010_0000,
   parameter int          TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        rd_req,
   input  logic [31:0] rd_row,
   input  logic [31:0] rd_col,
   input  logic        wr_req,
   input  logic [31:0] wr_row,
   input  logic [31:0] wr_col,
   input  logic [31:0] wr_data,
   input  logic        err_clr,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        wr_done,
   output logic        busy,
   output logic        err,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   input  logic        avm_writeresponsevalid
);

   localparam int              CW      = $clog2(TIMEOUT + 1);
   localparam logic [31:0]     W32     = 32'(IMG_WIDTH);
   localparam logic [31:0]     H32     = 32'(IMG_HEIGHT);
   localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD, WR_WAIT, RESP} state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        bad;
   } wr_ent_t;

   function automatic logic [31:0] pix_addr(input logic [31:0] base, input logic [31:0] row,
                                            input logic [31:0] col);
      return base + ((row * W32 + col) << 2);
   endfunction

   // Unsigned compare also rejects negative coordinates (sign bit makes them huge).
   function automatic logic out_of_range(input logic [31:0] row, input logic [31:0] col);
      return (row >= H32) || (col >= W32);
   endfunction

   state_t        state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          pend_q, pend_d;
   wr_ent_t       pw_q, pw_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          wr_done_q, wr_done_d;
   logic          err_q, err_d;
   logic          resp_rd_q, resp_rd_d;

   logic rd_bad, wr_bad, err_set, rd_fin, wr_fin;

   assign rd_bad = out_of_range(rd_row, rd_col);
   assign wr_bad = out_of_range(wr_row, wr_col);
   assign busy   = (state_q != IDLE) || pend_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      pend_d     = pend_q;
      pw_d       = pw_q;
      cnt_d      = '0;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      wr_done_d  = 1'b0;
      resp_rd_d  = resp_rd_q;
      err_set    = busy && (rd_req || wr_req);
      rd_fin     = 1'b0;
      wr_fin     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!pend_q) begin
               if (rd_req) begin
                  addr_d    = pix_addr(RD_BASE, rd_row, rd_col);
                  resp_rd_d = 1'b1;
                  if (rd_bad) begin
                     err_set = 1'b1;
                     state_d = RESP;
                  end else begin
                     state_d = RD_CMD;
                  end
                  // A write arriving with a read is parked until the read finishes.
                  if (wr_req) begin
                     pend_d = 1'b1;
                     pw_d   = '{addr: pix_addr(WR_BASE, wr_row, wr_col), data: wr_data, bad: wr_bad};
                     if (wr_bad) err_set = 1'b1;
                  end
               end else if (wr_req) begin
                  addr_d    = pix_addr(WR_BASE, wr_row, wr_col);
                  wdata_d   = wr_data;
                  resp_rd_d = 1'b0;
                  if (wr_bad) begin
                     err_set = 1'b1;
                     state_d = RESP;
                  end else begin
                     state_d = WR_CMD;
                  end
               end
            end
         end
         RD_CMD: if (!avm_waitrequest) state_d = RD_WAIT;
         RD_WAIT: begin
            if (avm_readdatavalid) begin
               rd_data_d = avm_readdata;
               rd_fin    = 1'b1;
            end else if (cnt_q == TO_LAST) begin
               rd_data_d = '0;
               err_set   = 1'b1;
               rd_fin    = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WR_CMD: if (!avm_waitrequest) state_d = WR_WAIT;
         WR_WAIT: begin
            if (avm_writeresponsevalid) begin
               wr_fin = 1'b1;
            end else if (cnt_q == TO_LAST) begin
               err_set = 1'b1;
               wr_fin  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (resp_rd_q) begin
               rd_data_d = '0;
               rd_fin    = 1'b1;
            end else begin
               wr_fin = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rd_fin) begin
         rd_valid_d = 1'b1;
         if (pend_q) begin
            pend_d    = 1'b0;
            addr_d    = pw_q.addr;
            wdata_d   = pw_q.data;
            resp_rd_d = 1'b0;
            state_d   = pw_q.bad ? RESP : WR_CMD;
         end else begin
            state_d = IDLE;
         end
      end
      if (wr_fin) begin
         wr_done_d = 1'b1;
         state_d   = IDLE;
      end

      err_d = err_set | (err_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         pend_q     <= 1'b0;
         pw_q       <= '0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         wr_done_q  <= 1'b0;
         err_q      <= 1'b0;
         resp_rd_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         pend_q     <= pend_d;
         pw_q       <= pw_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         wr_done_q  <= wr_done_d;
         err_q      <= err_d;
         resp_rd_q  <= resp_rd_d;
      end
   end

   // Commands decode straight from the state flop so reset kills them at once.
   assign avm_read       = (state_q == RD_CMD);
   assign avm_write      = (state_q == WR_CMD);
   assign avm_byteenable = (avm_read || avm_write) ? 4'hF : 4'h0;
   assign avm_address    = addr_q;
   assign avm_writedata  = wdata_q;
   assign rd_data        = rd_data_q;
   assign rd_valid       = rd_valid_q;
   assign wr_done        = wr_done_q;
   assign err            = err_q;

endmodule

// File: doc/avalon_master_bridge.md
Name: avalon_master_bridge

Overview:
Avalon-MM master front end for the cartoonifier datapath. It sits directly downstream of the cartoonifier core and its sequencer. It converts the core's row/column read and write requests into word-addressed Avalon-MM transactions on the SDRAM port, and returns read data and write completions back to the core. It handles waitrequest stalls, response waits, response timeouts and out-of-range coordinates.

Parameters:
IMG_WIDTH, 640, pixels per row.
IMG_HEIGHT, 480, rows per image.
RD_BASE, 32'h0000_0000, byte base address of the source image.
WR_BASE, 32'h0010_0000, byte base address of the output image.
TIMEOUT, 255, maximum cycles spent in a response-wait state before abort.

Ports:
clk  in  1  system clock, rising edge.
n_rst  in  1  asynchronous active-low reset.
rd_req  in  1  single-cycle read request pulse.
rd_row  in  32  signed integer, read row.
rd_col  in  32  signed integer, read column.
wr_req  in  1  single-cycle write request pulse.
wr_row  in  32  signed integer, write row.
wr_col  in  32  signed integer, write column.
wr_data  in  32  pixel word to write.
err_clr  in  1  clears err.
rd_data  out  32  returned read word.
rd_valid  out  1  one-cycle pulse; rd_data valid.
wr_done  out  1  one-cycle pulse; write completed.
busy  out  1  high when not idle or a write is pending.
err  out  1  sticky error flag.
avm_address  out  32  byte address.
avm_read  out  1  Avalon read command.
avm_write  out  1  Avalon write command.
avm_writedata  out  32  write data.
avm_byteenable  out  4  byte lanes.
avm_waitrequest  in  1  slave stall.
avm_readdata  in  32  slave read data.
avm_readdatavalid  in  1  read data strobe.
avm_writeresponsevalid  in  1  write response strobe.

Behaviour:
- Reset (async, n_rst=0):
  - All outputs are 0.
  - FSM goes to IDLE; pending write and timeout counter are cleared.
  - avm_read and avm_write drop immediately, without waiting for a clock edge.
- FSM states: IDLE, RD_CMD, RD_WAIT, WR_CMD, WR_WAIT, RESP.
- Address calculation, registered at acceptance: BASE + ((row*IMG_WIDTH + col) << 2), computed in 32-bit unsigned arithmetic. avm_byteenable = 4'hF whenever avm_read or avm_write is high; otherwise 0.
- Range check: row<0, row>=IMG_HEIGHT, col<0 or col>=IMG_WIDTH makes a request invalid. An invalid request:
  - issues no bus command;
  - sets err;
  - goes to RESP, which emits the normal completion pulse (rd_valid with rd_data=0, or wr_done) on the next cycle, then returns to IDLE.
- Acceptance: requests are accepted only in IDLE with no pending write.
  - rd_req alone: latch the address and go to RD_CMD.
  - wr_req alone: latch the address and wr_data, go to WR_CMD.
  - rd_req and wr_req in the same cycle: the read wins. The write address and data go into a one-entry pending register, and busy stays high.
  - A request pulse arriving while busy=1 is ignored and sets err.
- RD_CMD:
  - avm_read=1 with avm_address stable.
  - avm_read is held while avm_waitrequest=1.
  - On a clock edge with waitrequest=0, go to RD_WAIT with avm_read=0.
  - avm_readdatavalid is ignored in RD_CMD.
- RD_WAIT:
  - On avm_readdatavalid, register avm_readdata into rd_data and pulse rd_valid on the next cycle.
  - Then go to IDLE, or to WR_CMD if a write is pending.
  - rd_data holds its value until the next read completes.
- WR_CMD / WR_WAIT: same rules as the read path, using avm_write, avm_writedata and avm_writeresponsevalid. wr_done pulses on the cycle after the response.
- Minimum latency: request at cycle N, command at N+1, response at N+2, completion pulse at N+3.
- Timeout: a counter runs only in RD_WAIT and WR_WAIT. When it reaches TIMEOUT without a response:
  - set err;
  - complete with rd_data=0 (read) or wr_done (write).
  - A late response that arrives in any other state is ignored.
- Waitrequest stalls in the CMD states are unbounded and have no timeout.
- err is set by any error source, cleared by err_clr, and set wins if both occur in the same cycle.
- busy is 0 only in IDLE with no pending write.

Test Plan:
1. Read path with stall. Stimulus: rd_req, row=2, col=3; waitrequest high 2 cycles; readdatavalid 3 cycles later with 0xA5A5A5A5. Required: avm_address=0x0000140C; avm_read held exactly 3 cycles; rd_data=0xA5A5A5A5; single rd_valid pulse; busy low afterwards.
2. Write path. Stimulus: wr_req, row=0, col=1, wr_data=0x00FF8040; writeresponsevalid 2 cycles after the command. Required: avm_address=0x00100004; avm_writedata=0x00FF8040; avm_byteenable=0xF; one wr_done pulse.
3. Simultaneous requests. Stimulus: rd_req and wr_req in the same cycle. Required: the read completes first; avm_write rises only after rd_valid; then wr_done; err stays 0.
4. Out-of-range read. Stimulus: rd_col=640. Required: no avm_read; err=1; rd_valid with rd_data=0 two cycles after the request. Then err_clr returns err to 0.
5. Read timeout. Stimulus: command accepted, no readdatavalid. Required: after 255 wait cycles, err=1 and rd_valid with rd_data=0. A readdatavalid arriving afterwards has no effect.
6. Reset mid-command. Stimulus: n_rst low during RD_CMD with waitrequest=1. Required: avm_read=0 immediately, busy=0, err=0. After reset is released, a new read of row=0, col=0 targets 0x00000000.
